param_instr_memory: RTL and testbench

Parametrised instruction/data word memory that succeeds the fixed 25x32 instruction store. It provides one registered read port for fetch and one byte-enabled write port for program loading, with configurable width and depth and out-of-range error flags. Reset starts a hardware clear sequence that zeroes every word, with a busy indication. It sits between the PC/fetch stage and the program loader.

---
 rtl/imem_pkg.sv | 43 ++++
 rtl/param_instr_memory_if.sv | 33 +++
 rtl/imem_clear_fsm.sv | 59 +++++
 rtl/param_instr_memory.sv | 118 +++++++++++
 tb/tb_param_instr_memory.sv | 230 +++++++++++++++++++++++
 5 files changed

// File: rtl/imem_pkg.sv
// Shared definitions for the parametrised instruction/data word memory.
//   imem_state_t : clear/ready state of the memory controller
//   addr_w_f     : address width derived from the word count
//   be_w_f       : byte-enable width derived from the word width
//   be_merge     : overlay write data onto a stored word under byte enables
package imem_pkg;

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } imem_state_t;

  // be_merge works on the widest supported word; callers zero-extend their
  // operands and truncate the result back to their own width.
  localparam int MAX_DATA_W = 256;
  localparam int MAX_BE_W   = MAX_DATA_W / 8;

  typedef logic [MAX_DATA_W-1:0] word_max_t;
  typedef logic [MAX_BE_W-1:0]   be_max_t;

  // A single word still needs a one-bit address.
  function automatic int addr_w_f(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  function automatic int be_w_f(input int data_w);
    return data_w / 8;
  endfunction

  function automatic word_max_t be_merge(input word_max_t old_word,
                                         input word_max_t new_word,
                                         input be_max_t   be);
    word_max_t result;
    result = old_word;
    for (int i = 0; i < MAX_BE_W; i++) begin
      if (be[i]) begin
        result[i*8 +: 8] = new_word[i*8 +: 8];
      end
    end
    return result;
  endfunction

endpackage

// File: rtl/param_instr_memory_if.sv
// Bus bundle between the fetch stage / program loader and the word memory.
//   master : drives read and write requests, receives data, flags and busy
//   slave  : the memory side
interface param_instr_memory_if import imem_pkg::*; #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 32
);
  localparam int ADDR_W = addr_w_f(DEPTH);
  localparam int BE_W   = be_w_f(DATA_W);

  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;
  logic              rd_err;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic [BE_W-1:0]   wr_be;
  logic              wr_err;
  logic              busy;

  modport master (
    output rd_en, rd_addr, wr_en, wr_addr, wr_data, wr_be,
    input  rd_data, rd_valid, rd_err, wr_err, busy
  );

  modport slave (
    input  rd_en, rd_addr, wr_en, wr_addr, wr_data, wr_be,
    output rd_data, rd_valid, rd_err, wr_err, busy
  );

endinterface

// File: rtl/imem_clear_fsm.sv
// Post-reset clear sequencer: walks every word address once, requesting a
// zero write per cycle, then settles in READY until the next reset.
//   clk, rst  : clock, asynchronous active-high reset
//   busy      : clear sequence in progress
//   clr_we    : request to write zero this cycle
//   clr_addr  : word address to clear this cycle
module imem_clear_fsm import imem_pkg::*; #(
  parameter int DEPTH  = 32,
  parameter int ADDR_W = addr_w_f(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  output logic              busy,
  output logic              clr_we,
  output logic [ADDR_W-1:0] clr_addr
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  imem_state_t       state_reg, state_next;
  logic [ADDR_W-1:0] clr_ptr_reg, clr_ptr_next;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg   <= CLEAR;
      clr_ptr_reg <= '0;
    end else begin
      state_reg   <= state_next;
      clr_ptr_reg <= clr_ptr_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    clr_ptr_next = clr_ptr_reg;
    clr_we       = 1'b0;
    case (state_reg)
      CLEAR: begin
        clr_we = 1'b1;
        if (clr_ptr_reg == LAST_ADDR) begin
          state_next   = READY;
          clr_ptr_next = '0;
        end else begin
          clr_ptr_next = clr_ptr_reg + 1'b1;
        end
      end
      READY: begin
        state_next = READY;
      end
      default: begin
        state_next = CLEAR;
      end
    endcase
  end

  assign busy     = (state_reg == CLEAR);
  assign clr_addr = clr_ptr_reg;

endmodule

// File: rtl/param_instr_memory.sv
// Parametrised word memory: one registered read port for fetch, one
// byte-enabled write port for program loading, out-of-range error pulses,
// and a hardware zero-fill after every reset.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : read/write request bundle, read data, valid/err flags, busy
module param_instr_memory import imem_pkg::*; #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  param_instr_memory_if.slave  bus
);

  localparam int ADDR_W = addr_w_f(DEPTH);
  localparam int BE_W   = be_w_f(DATA_W);

  // When DEPTH fills the address space no address can be out of range,
  // so the comparisons fold to constant 0.
  localparam bit                POW2      = (DEPTH == (1 << ADDR_W));
  localparam logic [ADDR_W:0]   DEPTH_EXT = (ADDR_W + 1)'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];

  logic              busy;
  logic              clr_we;
  logic [ADDR_W-1:0] clr_addr;

  imem_clear_fsm #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_clear_fsm (
    .clk      (clk),
    .rst      (rst),
    .busy     (busy),
    .clr_we   (clr_we),
    .clr_addr (clr_addr)
  );

  logic              rd_oob;
  logic              wr_oob;
  logic              wr_ok;
  logic [BE_W-1:0]   hit_be;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata;
  logic [BE_W-1:0]   mem_be;

  always_comb begin
    rd_oob = !POW2 && ({1'b0, bus.rd_addr} >= DEPTH_EXT);
    wr_oob = !POW2 && ({1'b0, bus.wr_addr} >= DEPTH_EXT);
    wr_ok  = bus.wr_en && !wr_oob;
    // Lanes the concurrent write overlays onto the read word (write-first).
    hit_be = (wr_ok && (bus.wr_addr == bus.rd_addr)) ? bus.wr_be : '0;

    // The clear sequencer owns the write port while busy.
    if (busy) begin
      mem_we    = clr_we;
      mem_waddr = clr_addr;
      mem_wdata = '0;
      mem_be    = '1;
    end else begin
      mem_we    = wr_ok;
      mem_waddr = bus.wr_addr;
      mem_wdata = bus.wr_data;
      mem_be    = bus.wr_be;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int i = 0; i < BE_W; i++) begin
        if (mem_be[i]) begin
          mem[mem_waddr][i*8 +: 8] <= mem_wdata[i*8 +: 8];
        end
      end
    end
  end

  logic [DATA_W-1:0] rd_data_reg;
  logic              rd_valid_reg;
  logic              rd_err_reg;
  logic              wr_err_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_data_reg  <= '0;
      rd_valid_reg <= 1'b0;
      rd_err_reg   <= 1'b0;
      wr_err_reg   <= 1'b0;
    end else if (busy) begin
      rd_data_reg  <= '0;
      rd_valid_reg <= 1'b0;
      rd_err_reg   <= 1'b0;
      wr_err_reg   <= 1'b0;
    end else begin
      rd_valid_reg <= bus.rd_en && !rd_oob;
      rd_err_reg   <= bus.rd_en && rd_oob;
      wr_err_reg   <= bus.wr_en && wr_oob;
      if (bus.rd_en) begin
        if (rd_oob) begin
          rd_data_reg <= '0;
        end else begin
          rd_data_reg <= DATA_W'(be_merge(word_max_t'(mem[bus.rd_addr]),
                                          word_max_t'(bus.wr_data),
                                          be_max_t'(hit_be)));
        end
      end
    end
  end

  assign bus.rd_data  = rd_data_reg;
  assign bus.rd_valid = rd_valid_reg;
  assign bus.rd_err   = rd_err_reg;
  assign bus.wr_err   = wr_err_reg;
  assign bus.busy     = busy;

endmodule

// File: tb/tb_param_instr_memory.sv
// Self-checking bench: a DEPTH=32 and a DEPTH=25 memory side by side.
// Directed vector table for single-cycle behaviour, hand-written sequences
// for the clear timing, full-array sweeps and reset during clear.
module tb_param_instr_memory;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  param_instr_memory_if #(.DATA_W(32), .DEPTH(32)) if32 ();
  param_instr_memory_if #(.DATA_W(32), .DEPTH(25)) if25 ();

  param_instr_memory #(.DATA_W(32), .DEPTH(32)) dut32 (
    .clk (clk),
    .rst (rst),
    .bus (if32.slave)
  );

  param_instr_memory #(.DATA_W(32), .DEPTH(25)) dut25 (
    .clk (clk),
    .rst (rst),
    .bus (if25.slave)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit          sel;      // 0: DEPTH=32 unit, 1: DEPTH=25 unit
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic [3:0]  be;
    logic        re;
    logic [4:0]  ra;
    logic [31:0] e_data;
    logic        e_valid;
    logic        e_rerr;
    logic        e_werr;
  } vec_t;

  localparam int NVEC = 22;
  vec_t vecs [NVEC];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_all;
    if32.rd_en = 1'b0; if32.rd_addr = '0; if32.wr_en = 1'b0;
    if32.wr_addr = '0; if32.wr_data = '0; if32.wr_be = '0;
    if25.rd_en = 1'b0; if25.rd_addr = '0; if25.wr_en = 1'b0;
    if25.wr_addr = '0; if25.wr_data = '0; if25.wr_be = '0;
  endtask

  task automatic drive(input bit sel, input logic we, input logic [4:0] wa,
                       input logic [31:0] wd, input logic [3:0] be,
                       input logic re, input logic [4:0] ra);
    idle_all();
    if (sel == 1'b0) begin
      if32.wr_en = we; if32.wr_addr = wa; if32.wr_data = wd; if32.wr_be = be;
      if32.rd_en = re; if32.rd_addr = ra;
    end else begin
      if25.wr_en = we; if25.wr_addr = wa; if25.wr_data = wd; if25.wr_be = be;
      if25.rd_en = re; if25.rd_addr = ra;
    end
  endtask

  task automatic sample(input bit sel, output logic [31:0] d, output logic v,
                        output logic rerr, output logic werr, output logic bz);
    if (sel == 1'b0) begin
      d = if32.rd_data; v = if32.rd_valid; rerr = if32.rd_err;
      werr = if32.wr_err; bz = if32.busy;
    end else begin
      d = if25.rd_data; v = if25.rd_valid; rerr = if25.rd_err;
      werr = if25.wr_err; bz = if25.busy;
    end
  endtask

  // Read every address; all expected zero except optionally one.
  task automatic sweep(input bit sel, input int depth, input int sp_addr,
                       input logic [31:0] sp_val);
    logic [31:0] d, e;
    logic v, rerr, werr, bz;
    for (int a = 0; a < depth; a++) begin
      drive(sel, 1'b0, 5'd0, 32'd0, 4'd0, 1'b1, 5'(a));
      tick();
      sample(sel, d, v, rerr, werr, bz);
      e = (a == sp_addr) ? sp_val : 32'd0;
      $display("sweep d%0d addr %0d data %h valid %0b", depth, a, d, v);
      chk($sformatf("sweep%0d[%0d].data", depth, a), d, e);
      chk($sformatf("sweep%0d[%0d].valid", depth, a), 32'(v), 32'd1);
    end
    idle_all();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, checks %0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d;
    logic v, rerr, werr, bz;
    int c32, c25, bad;

    //            sel we wa     wd             be    re ra     e_data         v  re we
    vecs[0]  = '{1'b0,1'b1,5'd5, 32'hDEADBEEF,4'hF,1'b0,5'd0, 32'h00000000,1'b0,1'b0,1'b0};
    vecs[1]  = '{1'b0,1'b0,5'd0, 32'h00000000,4'h0,1'b1,5'd5, 32'hDEADBEEF,1'b1,1'b0,1'b0};
    vecs[2]  = '{1'b0,1'b0,5'd0, 32'h00000000,4'h0,1'b0,5'd0, 32'hDEADBEEF,1'b0,1'b0,1'b0};
    vecs[3]  = '{1'b0,1'b1,5'd7, 32'h11223344,4'hF,1'b0,5'd0, 32'hDEADBEEF,1'b0,1'b0,1'b0};
    vecs[4]  = '{1'b0,1'b1,5'd7, 32'hAABBCCDD,4'h5,1'b0,5'd0, 32'hDEADBEEF,1'b0,1'b0,1'b0};
    vecs[5]  = '{1'b0,1'b0,5'd0, 32'h00000000,4'h0,1'b1,5'd7, 32'h11BB33DD,1'b1,1'b0,1'b0};
    vecs[6]  = '{1'b0,1'b1,5'd9, 32'h00000000,4'hF,1'b0,5'd0, 32'h11BB33DD,1'b0,1'b0,1'b0};
    vecs[7]  = '{1'b0,1'b1,5'd9, 32'h000000FF,4'h1,1'b1,5'd9, 32'h000000FF,1'b1,1'b0,1'b0};
    vecs[8]  = '{1'b0,1'b0,5'd0, 32'h00000000,4'h0,1'b1,5'd9, 32'h000000FF,1'b1,1'b0,1'b0};
    vecs[9]  = '{1'b0,1'b1,5'd3, 32'h12345678,4'hF,1'b1,5'd5, 32'hDEADBEEF,1'b1,1'b0,1'b0};
    vecs[10] = '{1'b0,1'b0,5'd0, 32'h00000000,4'h0,1'b1,5'd3, 32'h12345678,1'b1,1'b0,1'b0};
    vecs[11] = '{1'b0,1'b1,5'd31,32'hCAFEF00D,4'hF,1'b1,5'd31,32'hCAFEF00D,1'b1,1'b0,1'b0};
    vecs[12] = '{1'b0,1'b1,5'd7, 32'hFFFFFFFF,4'h0,1'b1,5'd7, 32'h11BB33DD,1'b1,1'b0,1'b0};
    vecs[13] = '{1'b0,1'b0,5'd0, 32'h00000000,4'h0,1'b1,5'd7, 32'h11BB33DD,1'b1,1'b0,1'b0};
    vecs[14] = '{1'b1,1'b1,5'd24,32'h55AA55AA,4'hF,1'b0,5'd0, 32'h00000000,1'b0,1'b0,1'b0};
    vecs[15] = '{1'b1,1'b1,5'd30,32'hFFFFFFFF,4'hF,1'b0,5'd0, 32'h00000000,1'b0,1'b0,1'b1};
    vecs[16] = '{1'b1,1'b0,5'd0, 32'h00000000,4'h0,1'b0,5'd0, 32'h00000000,1'b0,1'b0,1'b0};
    vecs[17] = '{1'b1,1'b0,5'd0, 32'h00000000,4'h0,1'b1,5'd24,32'h55AA55AA,1'b1,1'b0,1'b0};
    vecs[18] = '{1'b1,1'b0,5'd0, 32'h00000000,4'h0,1'b1,5'd27,32'h00000000,1'b0,1'b1,1'b0};
    vecs[19] = '{1'b1,1'b1,5'd30,32'h12345678,4'hF,1'b1,5'd27,32'h00000000,1'b0,1'b1,1'b1};
    vecs[20] = '{1'b1,1'b1,5'd24,32'h00001100,4'h2,1'b1,5'd24,32'h55AA11AA,1'b1,1'b0,1'b0};
    vecs[21] = '{1'b1,1'b0,5'd0, 32'h00000000,4'h0,1'b0,5'd0, 32'h55AA11AA,1'b0,1'b0,1'b0};

    idle_all();
    rst = 1'b1;
    repeat (3) tick();

    // Reset state of both units.
    for (int s = 0; s < 2; s++) begin
      sample(1'(s), d, v, rerr, werr, bz);
      $display("reset unit %0d data %h valid %0b rerr %0b werr %0b busy %0b", s, d, v, rerr, werr, bz);
      chk($sformatf("reset%0d.data", s), d, 32'd0);
      chk($sformatf("reset%0d.valid", s), 32'(v), 32'd0);
      chk($sformatf("reset%0d.rd_err", s), 32'(rerr), 32'd0);
      chk($sformatf("reset%0d.wr_err", s), 32'(werr), 32'd0);
      chk($sformatf("reset%0d.busy", s), 32'(bz), 32'd1);
    end

    // Clear length after deassert: DEPTH cycles.
    rst = 1'b0;
    c32 = 0; c25 = 0;
    for (int n = 0; n < 100; n++) begin
      if (!if32.busy && !if25.busy) break;
      if (if32.busy) c32++;
      if (if25.busy) c25++;
      tick();
    end
    $display("clear cycles d32 %0d d25 %0d", c32, c25);
    chk("clear_len32", 32'(c32), 32'd32);
    chk("clear_len25", 32'(c25), 32'd25);

    sweep(1'b0, 32, -1, 32'd0);
    sweep(1'b1, 25, -1, 32'd0);

    // Table of single-cycle transactions.
    for (int i = 0; i < NVEC; i++) begin
      drive(vecs[i].sel, vecs[i].we, vecs[i].wa, vecs[i].wd, vecs[i].be,
            vecs[i].re, vecs[i].ra);
      tick();
      sample(vecs[i].sel, d, v, rerr, werr, bz);
      $display("vec %0d unit %0d data %h valid %0b rerr %0b werr %0b", i, vecs[i].sel, d, v, rerr, werr);
      chk($sformatf("vec%0d.data", i), d, vecs[i].e_data);
      chk($sformatf("vec%0d.valid", i), 32'(v), 32'(vecs[i].e_valid));
      chk($sformatf("vec%0d.rd_err", i), 32'(rerr), 32'(vecs[i].e_rerr));
      chk($sformatf("vec%0d.wr_err", i), 32'(werr), 32'(vecs[i].e_werr));
    end
    idle_all();

    // Out-of-range writes left the 25-word array intact.
    sweep(1'b1, 25, 24, 32'h55AA11AA);

    // Reset during clear: pulse, wait 10 cycles, pulse twice more.
    rst = 1'b1; tick(); rst = 1'b0;
    repeat (10) tick();
    chk("midclear.busy32", 32'(if32.busy), 32'd1);
    rst = 1'b1; tick(); rst = 1'b0;
    tick();
    rst = 1'b1; tick(); rst = 1'b0;

    // Accesses while busy must be ignored and raise nothing.
    c32 = 0; c25 = 0; bad = 0;
    for (int n = 0; n < 100; n++) begin
      if (!if32.busy && !if25.busy) break;
      idle_all();
      if (if32.busy) begin
        c32++;
        if32.wr_en = 1'b1; if32.wr_addr = 5'd3; if32.wr_data = 32'hFFFFFFFF;
        if32.wr_be = 4'hF; if32.rd_en = 1'b1; if32.rd_addr = 5'd5;
      end
      if (if25.busy) begin
        c25++;
        if25.wr_en = 1'b1; if25.wr_addr = 5'(n & 1 ? 30 : 3);
        if25.wr_data = 32'hFFFFFFFF; if25.wr_be = 4'hF;
        if25.rd_en = 1'b1; if25.rd_addr = 5'd27;
      end
      tick();
      if (if32.rd_valid || if32.rd_err || if32.wr_err || (if32.rd_data != 0)) bad++;
      if (if25.rd_valid || if25.rd_err || if25.wr_err || (if25.rd_data != 0)) bad++;
    end
    idle_all();
    $display("restart clear d32 %0d d25 %0d side_effects %0d", c32, c25, bad);
    chk("restart.len32", 32'(c32), 32'd32);
    chk("restart.len25", 32'(c25), 32'd25);
    chk("restart.busy_side_effects", 32'(bad), 32'd0);

    sweep(1'b0, 32, -1, 32'd0);
    sweep(1'b1, 25, -1, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
